cond_unit: RTL
==============

# cond_unit

Conditional-execution unit for the single-cycle processor: it consumes the NZCV flags produced by the ALU flag generator and holds them in an architectural flags register. It evaluates each instruction's 4-bit condition field against the stored flags and gates the instruction's write and branch controls. It also keeps saturating counts of executed and squashed instructions for debug. It sits between the control decoder and the register file, memory and PC logic.

## Interface

- CNT_W, 16, width of the executed/squashed counters.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  a real instruction is present this cycle; 0 = bubble.
- cond  in  4  condition field of the current instruction.
- alu_flags  in  4  {N,Z,C,V} from the ALU flag generator for the current instruction.
- flag_w  in  2  flag-write request: bit1 = update N,Z; bit0 = update C,V.
- pc_src  in  1  decoder branch/PC-write request.
- reg_write  in  1  decoder register-write request.
- mem_write  in  1  decoder memory-write request.
- no_write  in  1  compare-class instruction; suppresses the register write.
- cnt_clr  in  1  synchronous clear of both counters.
- cond_ex  out  1  condition passed for the current instruction.
- pc_src_out  out  1  gated PC write.
- reg_write_out  out  1  gated register write.
- mem_write_out  out  1  gated memory write.
- flags_q  out  4  architectural {N,Z,C,V} register.
- exec_cnt  out  CNT_W  instructions executed since reset/clear.
- skip_cnt  out  CNT_W  instructions squashed since reset/clear.

## Operation

- Condition decode uses flags_q, not alu_flags:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 treated as 1.
- cond_ex = instr_valid & decode(cond). A bubble always gives cond_ex = 0.
- Output gating:
  - pc_src_out = pc_src & cond_ex.
  - reg_write_out = reg_write & cond_ex & !no_write.
  - mem_write_out = mem_write & cond_ex.
- Flags register:
  - If cond_ex & flag_w[1], latch N,Z from alu_flags[3:2].
  - If cond_ex & flag_w[0], latch C,V from alu_flags[1:0].
  - Halves update independently. A squashed instruction never updates flags.
- Counters, evaluated in priority order:
  - cnt_clr: both counters go to 0. The current instruction is not counted.
  - Else if instr_valid & cond_ex: exec_cnt increments.
  - Else if instr_valid & !cond_ex: skip_cnt increments.
  - Bubbles count nowhere.
  - Both counters saturate at 2^CNT_W−1 and never wrap.

## Timing

- Reset (rst_n low, asynchronous):
  - flags_q = 4'b0000, exec_cnt = 0, skip_cnt = 0.
  - cond_ex and the gated outputs follow combinationally from flags_q = 0 (e.g. EQ fails, NE passes when valid).
- cond_ex and the gated outputs are combinational, zero latency within the instruction's cycle.
- Flag writes become visible one cycle later:
  - An instruction sees flags from strictly earlier instructions.
  - An instruction's own flag_w never affects its own cond_ex (no same-cycle bypass).
- Counters update on the edge ending the instruction's cycle.
- rst_n released mid-stream: the first edge after release behaves as a normal cycle.

## Test plan

- Reset then cond=0001 (NE), instr_valid=1, reg_write=1: cond_ex=1, reg_write_out=1. After the edge, exec_cnt=1, flags_q=0000.
- CMP with alu_flags=0100, flag_w=11, cond=1110: flags_q=0100 next cycle. Next, cond=0000 with mem_write=1 gives mem_write_out=1. cond=0001 gives mem_write_out=0 and skip_cnt increments.
- Partial update: flags_q=1001, then flag_w=10 with alu_flags=0110 -> flags_q=0101 (C,V kept).
- Squashed flag write: flags_q=0000, cond=0000, flag_w=11, alu_flags=1111 -> cond_ex=0, flags_q stays 0000, pc_src_out=0.
- Signed conditions: flags_q=1000 -> LT, LE, NE, MI pass; GE, GT fail. flags_q=1001 -> GE, GT pass.
- Counter saturation and clear, with CNT_W=4:
  - 20 executed instructions -> exec_cnt=15.
  - cnt_clr together with a valid instruction -> both counters 0.
  - Bubble cycles (instr_valid=0) leave both counters unchanged and all gated outputs 0.

Source files
------------

// File: rtl/cond_unit.sv
// Conditional-execution unit: holds the NZCV flags register, evaluates the
// condition field and gates write/branch controls; keeps debug execute/squash counts.
module cond_unit #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [3:0]       cond,
  input  logic [3:0]       alu_flags,
  input  logic [1:0]       flag_w,
  input  logic             pc_src,
  input  logic             reg_write,
  input  logic             mem_write,
  input  logic             no_write,
  input  logic             cnt_clr,
  output logic             cond_ex,
  output logic             pc_src_out,
  output logic             reg_write_out,
  output logic             mem_write_out,
  output logic [3:0]       flags_q,
  output logic [CNT_W-1:0] exec_cnt,
  output logic [CNT_W-1:0] skip_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             n_f, z_f, c_f, v_f;
  logic             cond_pass;
  logic [3:0]       flags_d;
  logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
  logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;

  // Decode reads the registered flags only, so an instruction never sees its own flag write.
  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cond_pass = 1'b1;
    case (cond)
      4'b0000: cond_pass = z_f;
      4'b0001: cond_pass = !z_f;
      4'b0010: cond_pass = c_f;
      4'b0011: cond_pass = !c_f;
      4'b0100: cond_pass = n_f;
      4'b0101: cond_pass = !n_f;
      4'b0110: cond_pass = v_f;
      4'b0111: cond_pass = !v_f;
      4'b1000: cond_pass = c_f && !z_f;
      4'b1001: cond_pass = !c_f || z_f;
      4'b1010: cond_pass = (n_f == v_f);
      4'b1011: cond_pass = (n_f != v_f);
      4'b1100: cond_pass = !z_f && (n_f == v_f);
      4'b1101: cond_pass = z_f || (n_f != v_f);
      default: cond_pass = 1'b1;
    endcase
  end

  assign cond_ex       = instr_valid & cond_pass;
  assign pc_src_out    = pc_src & cond_ex;
  assign reg_write_out = reg_write & cond_ex & !no_write;
  assign mem_write_out = mem_write & cond_ex;

  // N,Z and C,V halves update independently.
  always_comb begin
    flags_d = flags_q;
    if (cond_ex && flag_w[1]) flags_d[3:2] = alu_flags[3:2];
    if (cond_ex && flag_w[0]) flags_d[1:0] = alu_flags[1:0];
  end

  always_comb begin
    exec_cnt_d = exec_cnt_q;
    skip_cnt_d = skip_cnt_q;
    if (cnt_clr) begin
      exec_cnt_d = '0;
      skip_cnt_d = '0;
    end else if (cond_ex) begin
      if (exec_cnt_q != CNT_MAX) exec_cnt_d = exec_cnt_q + CNT_ONE;
    end else if (instr_valid) begin
      if (skip_cnt_q != CNT_MAX) skip_cnt_d = skip_cnt_q + CNT_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q    <= 4'b0000;
      exec_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else begin
      flags_q    <= flags_d;
      exec_cnt_q <= exec_cnt_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  assign exec_cnt = exec_cnt_q;
  assign skip_cnt = skip_cnt_q;

endmodule
